// File: rtl/td4_core.sv
// TD4 4-bit CPU fetch/execute core: PC, A, B, carry and output latch, one instruction per enabled edge.
// Optional macro TD4_HALT_EN: a self-targeting JMP or taken JNC latches halted and freezes the core until rst.
module td4_core #(
  parameter logic [3:0] PC_RESET  = 4'h0,
  parameter logic [3:0] OUT_RESET = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b,
  output logic       carry,
  output logic       halted
);

  localparam logic [3:0] OP_ADD_A = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A  = 4'b0010;
  localparam logic [3:0] OP_MOV_A = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B = 4'b0101;
  localparam logic [3:0] OP_IN_B  = 4'b0110;
  localparam logic [3:0] OP_MOV_B = 4'b0111;
  localparam logic [3:0] OP_OUT_B = 4'b1001;
  localparam logic [3:0] OP_OUT_I = 4'b1011;
  localparam logic [3:0] OP_JNC   = 4'b1110;
  localparam logic [3:0] OP_JMP   = 4'b1111;

  logic [3:0] pc_q, pc_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] out_q, out_d;
  logic       carry_q, carry_d;
  logic       exec;

  logic [3:0] op;
  logic [3:0] im;
  assign op = rom_data[7:4];
  assign im = rom_data[3:0];

  function automatic logic [4:0] add5(input logic [3:0] x, input logic [3:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

`ifdef TD4_HALT_EN
  logic halted_q, halted_d;
  logic self_jump;
  assign self_jump = ((op == OP_JMP) || ((op == OP_JNC) && !carry_q)) && (im == pc_q);
  assign exec      = en && !halted_q;
  assign halted_d  = halted_q || (exec && self_jump);
  assign halted    = halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end
`else
  assign exec   = en;
  assign halted = 1'b0;
`endif

  always_comb begin
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    if (exec) begin
      pc_d    = pc_q + 4'd1;
      carry_d = 1'b0;
      case (op)
        OP_ADD_A:  {carry_d, a_d} = add5(a_q, im);
        OP_ADD_B:  {carry_d, b_d} = add5(b_q, im);
        OP_MOV_A:  a_d = im;
        OP_MOV_B:  b_d = im;
        OP_MOV_AB: a_d = b_q;
        OP_MOV_BA: b_d = a_q;
        OP_IN_A:   a_d = in_port;
        OP_IN_B:   b_d = in_port;
        OP_OUT_B:  out_d = b_q;
        OP_OUT_I:  out_d = im;
        OP_JMP:    pc_d = im;
        // JNC tests the carry left by the previous instruction
        OP_JNC:    if (!carry_q) pc_d = im;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= PC_RESET;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      out_q   <= OUT_RESET;
      carry_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  assign rom_addr = pc_q;
  assign reg_a    = a_q;
  assign reg_b    = b_q;
  assign out_port = out_q;
  assign carry    = carry_q;

endmodule

// File: tb/tb_td4_core.sv
// Directed table-driven bench for td4_core; ROM modelled as a combinational array.
module tb_td4_core;

`ifdef TD4_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] in_port = 4'h0;
  logic [3:0] out_port, reg_a, reg_b;
  logic       carry, halted;

  logic [7:0] rom [16];
  assign rom_data = rom[rom_addr];

  td4_core #(.PC_RESET(4'h0), .OUT_RESET(4'h0)) dut (
    .clk(clk), .rst(rst), .en(en), .rom_addr(rom_addr), .rom_data(rom_data),
    .in_port(in_port), .out_port(out_port), .reg_a(reg_a), .reg_b(reg_b),
    .carry(carry), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] inp;
    logic [3:0] pc;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] outp;
    logic       h;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [17:0] exp);
    logic [17:0] act;
    act = {rom_addr, reg_a, reg_b, carry, out_port, halted};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got pc/a/b/c/out/h=%h/%h/%h/%b/%h/%b expected %h/%h/%h/%b/%h/%b",
               nm, act[17:14], act[13:10], act[9:6], act[5], act[4:1], act[0],
               exp[17:14], exp[13:10], exp[9:6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  task automatic add(input logic e, input logic [3:0] inp, input logic [3:0] pc,
                     input logic [3:0] a, input logic [3:0] b, input logic c,
                     input logic [3:0] outp, input logic h);
    vec_t v;
    v.en = e; v.inp = inp; v.pc = pc; v.a = a; v.b = b; v.c = c; v.outp = outp; v.h = h;
    tbl.push_back(v);
  endtask

  task automatic run_tbl(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      en      = tbl[i].en;
      in_port = tbl[i].inp;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", nm, i),
            {tbl[i].pc, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].outp, HALT ? tbl[i].h : 1'b0});
    end
    tbl.delete();
  endtask

  task automatic do_reset(input string nm);
    en  = 1'b0;
    rst = 1'b1;
    #2;
    check(nm, 18'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_prog1();
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    rom[0] = 8'h70; rom[1] = 8'h20; rom[2] = 8'h01; rom[3] = 8'h01;
    rom[4] = 8'h40; rom[5] = 8'h90; rom[6] = 8'hF6;
  endtask

  initial begin
    // Program 1 with en toggling; halts on JMP 6 when the halt feature is built in
    load_prog1();
    do_reset("reset1");
    add(1, 5, 4'h1, 4'h0, 4'h0, 0, 4'h0, 0);
    add(0, 5, 4'h1, 4'h0, 4'h0, 0, 4'h0, 0);
    add(0, 5, 4'h1, 4'h0, 4'h0, 0, 4'h0, 0);
    add(1, 5, 4'h2, 4'h5, 4'h0, 0, 4'h0, 0);
    add(1, 5, 4'h3, 4'h6, 4'h0, 0, 4'h0, 0);
    add(0, 5, 4'h3, 4'h6, 4'h0, 0, 4'h0, 0);
    add(1, 5, 4'h4, 4'h7, 4'h0, 0, 4'h0, 0);
    add(1, 5, 4'h5, 4'h7, 4'h7, 0, 4'h0, 0);
    add(1, 5, 4'h6, 4'h7, 4'h7, 0, 4'h7, 0);
    add(1, 5, 4'h6, 4'h7, 4'h7, 0, 4'h7, 1);
    add(1, 9, 4'h6, 4'h7, 4'h7, 0, 4'h7, 1);
    add(0, 9, 4'h6, 4'h7, 4'h7, 0, 4'h7, 1);
    run_tbl("prog1");

    // Async reset mid-run at PC=4, then restart from 0
    do_reset("reset2");
    add(1, 5, 4'h1, 4'h0, 4'h0, 0, 4'h0, 0);
    add(1, 5, 4'h2, 4'h5, 4'h0, 0, 4'h0, 0);
    add(1, 5, 4'h3, 4'h6, 4'h0, 0, 4'h0, 0);
    add(1, 5, 4'h4, 4'h7, 4'h0, 0, 4'h0, 0);
    run_tbl("prerst");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 18'h0);
    #2;
    rst = 1'b0;
    add(1, 5, 4'h1, 4'h0, 4'h0, 0, 4'h0, 0);
    add(1, 5, 4'h2, 4'h5, 4'h0, 0, 4'h0, 0);
    run_tbl("restart");

    // Carry and JNC: not taken when carry set, taken after carry cleared
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hE0; rom[3] = 8'hE0;
    do_reset("reset3");
    add(1, 0, 4'h1, 4'hF, 4'h0, 0, 4'h0, 0);
    add(1, 0, 4'h2, 4'h0, 4'h0, 1, 4'h0, 0);
    add(1, 0, 4'h3, 4'h0, 4'h0, 0, 4'h0, 0);
    add(1, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0);
    run_tbl("jnc");

    // PC wrap and OUT Im at address F
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    rom[15] = 8'hBA;
    do_reset("reset4");
    en = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("wrap15", {4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0});
    @(posedge clk);
    #1;
    check("wrap16", {4'h0, 4'h0, 4'h0, 1'b0, 4'hA, 1'b0});

    // ADD B overflow, MOV A,B, IN B, OUT Im, JNC to F, OUT B then wrap
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    rom[0] = 8'h7C; rom[1] = 8'h55; rom[2] = 8'h14; rom[3] = 8'h60;
    rom[4] = 8'hB3; rom[5] = 8'h05; rom[6] = 8'hEF; rom[15] = 8'h90;
    do_reset("reset5");
    add(1, 9, 4'h1, 4'h0, 4'hC, 0, 4'h0, 0);
    add(1, 9, 4'h2, 4'h0, 4'h1, 1, 4'h0, 0);
    add(1, 9, 4'h3, 4'h1, 4'h1, 0, 4'h0, 0);
    add(1, 9, 4'h4, 4'h1, 4'h9, 0, 4'h0, 0);
    add(1, 2, 4'h5, 4'h1, 4'h9, 0, 4'h3, 0);
    add(1, 2, 4'h6, 4'h6, 4'h9, 0, 4'h3, 0);
    add(1, 2, 4'hF, 4'h6, 4'h9, 0, 4'h3, 0);
    add(1, 2, 4'h0, 4'h6, 4'h9, 0, 4'h9, 0);
    run_tbl("misc");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
